// File: rtl/decode_pkg.sv
// Shared constants for the scanning one-hot decoder: mode select values and FSM encoding.
package decode_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIRECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;

endpackage

// File: rtl/decode_onehot.sv
// Combinational SEL_W-to-2^SEL_W one-hot decoder; all-zero when disabled.
module decode_onehot #(
    parameter int unsigned SEL_W = 2,
    localparam int unsigned OUT_N = 2 ** SEL_W
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_N-1:0] d
);

    always_comb begin
        d = '0;
        if (en) begin
            d[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with enable, driven either by a direct select bus or by an
// internal sequencer that steps through every line with a programmable dwell time.
module decoder_scan
    import decode_pkg::*;
#(
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned DWELL_W = 4,
    localparam int unsigned OUT_N  = 2 ** SEL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_N-1:0]   d,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               wrap
);

    logic [1:0]         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_d;
    logic               d_en;
    logic               wrap_d;
    logic [OUT_N-1:0]   d_d;

    // State is chosen from the inputs seen at each edge, and the actions follow that choice.
    always_comb begin
        if (!en) begin
            state_d = ST_IDLE;
        end else if (mode == MODE_SCAN) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_DIRECT;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        sel_d  = cur_sel;
        d_en   = 1'b0;
        wrap_d = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                sel_d = sel;
                cnt_d = '0;
                d_en  = 1'b1;
            end
            ST_SCAN: begin
                d_en = 1'b1;
                // >= lets a lowered dwell take effect at once instead of waiting for cnt to wrap.
                if (cnt_q >= dwell) begin
                    cnt_d  = '0;
                    sel_d  = cur_sel + SEL_W'(1);
                    wrap_d = &cur_sel;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            default: ;
        endcase
    end

    decode_onehot #(
        .SEL_W (SEL_W)
    ) u_decode_onehot (
        .en  (d_en),
        .sel (sel_d),
        .d   (d_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cur_sel <= '0;
            d       <= '0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_sel <= sel_d;
            d       <= d_d;
            wrap    <= wrap_d;
        end
    end

    always_comb begin
        assert ($onehot0(d));
        if (state_q != ST_SCAN) begin
            assert (!wrap);
        end
        if (state_q != ST_IDLE) begin
            assert (d != '0);
        end
    end

endmodule
